dmem_sram_bridge: RTL and testbench

Responder end of the data-memory request interface driven by the execute stage (en / wen[3:0] / addr / wdata).
- Converts each single-cycle-held request into one transaction on the SRAM-like data bus: req/wr/size/addr/wdata, with addr_ok/data_ok handshakes.
- Holds the pipeline with a stall request until the transaction completes.
- Returns load data to the memory stage.
- Sits between the execute stage and the data cache/AXI bridge.

---
 rtl/dmem_sram_bridge.sv | 197 +++++++++++++++++++
 tb/tb_dmem_sram_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram_bridge.sv
// -----------------------------------------------------------------------------
// dmem_sram_bridge
//
// Purpose:
//   Responder end of the execute-stage data-memory request interface. It turns
//   each held request (en / wen / addr / wdata) into exactly one transaction
//   on an SRAM-like bus (req / wr / size / addr / wdata, addr_ok / data_ok).
//   The pipeline is stalled until the transaction completes, and load data is
//   returned to the memory stage with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_i             pipeline flush from the controller
//   mem_en_i            request valid from execute (held while stalled)
//   mem_wen_i[3:0]      byte write enables, 0000 = load
//   mem_addr_i[31:0]    byte address
//   mem_wdata_i[31:0]   lane-aligned store data
//   mem_rdata_o[31:0]   load data (full word)
//   mem_rvalid_o        one-cycle pulse, load completed
//   mem_stallreq_o      stall request to the controller
//   data_req_o          bus request
//   data_wr_o           bus write (1) / read (0)
//   data_size_o[1:0]    0 = byte, 1 = half, 2 = word
//   data_addr_o[31:0]   bus address
//   data_wdata_o[31:0]  bus write data
//   data_addr_ok_i      bus accepted the request
//   data_data_ok_i      bus data phase done
//   data_rdata_i[31:0]  bus read data
//   stall_cnt_o         saturating count of stalled cycles
//
// States:
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no transaction; accepts a new request when en & ~flush
//   REQ    | data_req_o high, bus outputs held until addr_ok
//   WAIT   | address accepted, waiting for data_ok
//   DONE   | one-cycle completion; rvalid for non-cancelled loads
// -----------------------------------------------------------------------------
module dmem_sram_bridge #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             mem_en_i,
    input  logic [3:0]       mem_wen_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_wdata_i,
    output logic [31:0]      mem_rdata_o,
    output logic             mem_rvalid_o,
    output logic             mem_stallreq_o,
    output logic             data_req_o,
    output logic             data_wr_o,
    output logic [1:0]       data_size_o,
    output logic [31:0]      data_addr_o,
    output logic [31:0]      data_wdata_o,
    input  logic             data_addr_ok_i,
    input  logic             data_data_ok_i,
    input  logic [31:0]      data_rdata_i,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              cancel_q, cancel_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              accept;
    logic              stall;
    logic [1:0]        req_size;

    // Contiguous half-word enables map to size 1, single lanes to size 0;
    // anything irregular (and loads) is issued as a full word.
    function automatic logic [1:0] size_from_wen(input logic [3:0] wen);
        logic [1:0] sz;
        case (wen)
            4'b1111:                            sz = 2'd2;
            4'b0011, 4'b1100:                   sz = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cancel_d    = cancel_q;

        req_size    = size_from_wen(mem_wen_i);
        accept      = (state_q == S_IDLE) & mem_en_i & ~flush_i;
        stall       = accept | (state_q == S_REQ) | (state_q == S_WAIT);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_REQ;
                    wr_d     = |mem_wen_i;
                    size_d   = req_size;
                    addr_d   = (req_size == 2'd2) ? {mem_addr_i[31:2], 2'b00}
                                                  : mem_addr_i;
                    wdata_d  = mem_wdata_i;
                    cancel_d = 1'b0;
                end
            end
            S_REQ: begin
                if (data_addr_ok_i) begin
                    // Once the bus owns the request it must run to completion;
                    // a flush only suppresses the response.
                    cancel_d = cancel_q | flush_i;
                    if (data_data_ok_i) begin
                        state_d = S_DONE;
                        if (!wr_q) begin
                            rdata_d = data_rdata_i;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cancel_d = cancel_q | flush_i;
                if (data_data_ok_i) begin
                    state_d = S_DONE;
                    if (!wr_q) begin
                        rdata_d = data_rdata_i;
                    end
                end
            end
            S_DONE: begin
                // The request still held on mem_en_i belongs to this
                // transaction, so it is not re-accepted here.
                state_d  = S_IDLE;
                cancel_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            cancel_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cancel_q    <= cancel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign data_req_o     = (state_q == S_REQ);
    assign data_wr_o      = wr_q;
    assign data_size_o    = size_q;
    assign data_addr_o    = addr_q;
    assign data_wdata_o   = wdata_q;
    assign mem_rdata_o    = rdata_q;
    assign mem_rvalid_o   = (state_q == S_DONE) & ~wr_q & ~cancel_q;
    assign mem_stallreq_o = stall;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
module tb_dmem_sram_bridge;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic             mem_en_i;
    logic [3:0]       mem_wen_i;
    logic [31:0]      mem_addr_i;
    logic [31:0]      mem_wdata_i;
    logic [31:0]      mem_rdata_o;
    logic             mem_rvalid_o;
    logic             mem_stallreq_o;
    logic             data_req_o;
    logic             data_wr_o;
    logic [1:0]       data_size_o;
    logic [31:0]      data_addr_o;
    logic [31:0]      data_wdata_o;
    logic             data_addr_ok_i;
    logic             data_data_ok_i;
    logic [31:0]      data_rdata_i;
    logic [CNT_W-1:0] stall_cnt_o;

    dmem_sram_bridge #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .mem_en_i       (mem_en_i),
        .mem_wen_i      (mem_wen_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_rvalid_o   (mem_rvalid_o),
        .mem_stallreq_o (mem_stallreq_o),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] rd_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: bus acceptances and load responses.
    always @(negedge clk) begin
        bus_t b;
        logic [31:0] r;
        if (rst_n && data_req_o && data_addr_ok_i) begin
            if (bus_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_unexpected: addr %h accepted with no expected request", data_addr_o);
            end else begin
                b = bus_q.pop_front();
                chk("bus_wr",    {31'd0, data_wr_o},   {31'd0, b.wr});
                chk("bus_size",  {30'd0, data_size_o}, {30'd0, b.size});
                chk("bus_addr",  data_addr_o,  b.addr);
                chk("bus_wdata", data_wdata_o, b.wdata);
            end
        end
        if (rst_n && mem_rvalid_o) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rvalid_unexpected: rdata %h with no expected load", mem_rdata_o);
            end else begin
                r = rd_q.pop_front();
                chk("load_rdata", mem_rdata_o, r);
            end
        end
    end

    // One complete transaction. aok_wait = REQ cycles before addr_ok;
    // dok_wait = cycles after addr_ok until data_ok (0 = same cycle).
    task automatic txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_addr, input logic [1:0] exp_size,
                       input int aok_wait, input int dok_wait, input logic [31:0] rdata);
        bus_t e;
        e.wr = |wen; e.size = exp_size; e.addr = exp_addr; e.wdata = wdata;
        bus_q.push_back(e);
        if (wen == 4'b0000) rd_q.push_back(rdata);

        mem_en_i = 1'b1; mem_wen_i = wen; mem_addr_i = addr; mem_wdata_i = wdata;
        @(negedge clk);
        chk("stall_idle_req", {31'd0, mem_stallreq_o}, 32'd1);
        chk("req_in_idle",    {31'd0, data_req_o},     32'd0);
        tick();
        for (int i = 0; i < aok_wait; i++) begin
            @(negedge clk);
            chk("req_held", {31'd0, data_req_o},     32'd1);
            chk("stall_req", {31'd0, mem_stallreq_o}, 32'd1);
            tick();
        end
        data_addr_ok_i = 1'b1;
        data_data_ok_i = (dok_wait == 0);
        data_rdata_i   = (dok_wait == 0) ? rdata : JUNK;
        @(negedge clk);
        chk("req_at_aok", {31'd0, data_req_o}, 32'd1);
        tick();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = JUNK;
        if (dok_wait > 0) begin
            for (int i = 0; i < dok_wait - 1; i++) begin
                @(negedge clk);
                chk("req_wait",   {31'd0, data_req_o},     32'd0);
                chk("stall_wait", {31'd0, mem_stallreq_o}, 32'd1);
                tick();
            end
            data_data_ok_i = 1'b1; data_rdata_i = rdata;
            @(negedge clk);
            chk("stall_at_dok", {31'd0, mem_stallreq_o}, 32'd1);
            tick();
            data_data_ok_i = 1'b0; data_rdata_i = JUNK;
        end
        @(negedge clk);
        chk("stall_done",  {31'd0, mem_stallreq_o}, 32'd0);
        chk("req_done",    {31'd0, data_req_o},     32'd0);
        chk("rvalid_done", {31'd0, mem_rvalid_o},   {31'd0, (wen == 4'b0000)});
        tick();
        mem_en_i = 1'b0;
        @(negedge clk);
        chk("no_reaccept", {31'd0, mem_stallreq_o}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t e;
        rst_n = 1'b0; flush_i = 1'b0; mem_en_i = 1'b0; mem_wen_i = 4'd0;
        mem_addr_i = 32'd0; mem_wdata_i = 32'd0;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = JUNK;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",    {31'd0, data_req_o},   32'd0);
        chk("rst_wr",     {31'd0, data_wr_o},    32'd0);
        chk("rst_size",   {30'd0, data_size_o},  32'd0);
        chk("rst_addr",   data_addr_o,  32'd0);
        chk("rst_wdata",  data_wdata_o, 32'd0);
        chk("rst_rdata",  mem_rdata_o,  32'd0);
        chk("rst_rvalid", {31'd0, mem_rvalid_o}, 32'd0);
        chk("rst_cnt",    {28'd0, stall_cnt_o},  32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: word store, addr_ok cycle 2, data_ok cycle 4
        txn(4'b1111, 32'h8000_1006, 32'hDEAD_BEEF, 32'h8000_1004, 2'd2, 1, 2, JUNK);
        chk("stall_cnt_after_t1", {28'd0, stall_cnt_o}, 32'd5);

        // 2: byte, half, irregular-mask stores
        txn(4'b0100, 32'h8000_0002, 32'h00AB_0000, 32'h8000_0002, 2'd0, 0, 1, JUNK);
        txn(4'b1100, 32'h8000_0002, 32'hABCD_0000, 32'h8000_0002, 2'd1, 0, 1, JUNK);
        txn(4'b0001, 32'h8000_0007, 32'h0000_00EE, 32'h8000_0007, 2'd0, 2, 0, JUNK);
        txn(4'b0101, 32'h8000_0006, 32'h00CC_00DD, 32'h8000_0004, 2'd2, 0, 1, JUNK);

        // 3: load, addr_ok and data_ok together
        txn(4'b0000, 32'h8000_0003, 32'h0000_0000, 32'h8000_0000, 2'd2, 0, 0, 32'h1234_5678);

        // 4: load flushed in WAIT, data_ok three cycles later
        e.wr = 1'b0; e.size = 2'd2; e.addr = 32'h8000_0010; e.wdata = 32'd0;
        bus_q.push_back(e);
        mem_en_i = 1'b1; mem_wen_i = 4'b0000; mem_addr_i = 32'h8000_0012; mem_wdata_i = 32'd0;
        tick();
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0; flush_i = 1'b1; mem_en_i = 1'b0;
        @(negedge clk);
        chk("t4_stall_flush", {31'd0, mem_stallreq_o}, 32'd1);
        chk("t4_req_wait",    {31'd0, data_req_o},     32'd0);
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_stall_cancel", {31'd0, mem_stallreq_o}, 32'd1);
            tick();
        end
        data_data_ok_i = 1'b1; data_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t4_stall_dok", {31'd0, mem_stallreq_o}, 32'd1);
        tick();
        data_data_ok_i = 1'b0; data_rdata_i = JUNK;
        @(negedge clk);
        chk("t4_done_stall",  {31'd0, mem_stallreq_o}, 32'd0);
        chk("t4_done_rvalid", {31'd0, mem_rvalid_o},   32'd0);
        tick();
        txn(4'b0000, 32'h8000_0020, 32'h0000_0000, 32'h8000_0020, 2'd2, 1, 1, 32'h0F0E_0D0C);

        // flush in IDLE blocks acceptance
        mem_en_i = 1'b1; mem_wen_i = 4'b1111; flush_i = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", {31'd0, mem_stallreq_o}, 32'd0);
        tick();
        mem_en_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("idle_flush_req", {31'd0, data_req_o}, 32'd0);
        tick();

        // 5: load flushed in REQ before addr_ok; late data_ok ignored
        mem_en_i = 1'b1; mem_wen_i = 4'b0000; mem_addr_i = 32'h8000_0104;
        tick();
        flush_i = 1'b1;
        @(negedge clk);
        chk("t5_req_before_flush", {31'd0, data_req_o}, 32'd1);
        tick();
        flush_i = 1'b0; mem_en_i = 1'b0;
        @(negedge clk);
        chk("t5_req_dropped", {31'd0, data_req_o},     32'd0);
        chk("t5_stall_low",   {31'd0, mem_stallreq_o}, 32'd0);
        tick();
        data_data_ok_i = 1'b1;
        @(negedge clk);
        chk("t5_stray_dok_stall", {31'd0, mem_stallreq_o}, 32'd0);
        tick();
        data_data_ok_i = 1'b0;
        @(negedge clk);
        chk("t5_stray_dok_rvalid", {31'd0, mem_rvalid_o}, 32'd0);
        chk("t5_stray_dok_req",    {31'd0, data_req_o},   32'd0);
        tick();

        // 6: reset mid-WAIT, then counter saturation
        e.wr = 1'b1; e.size = 2'd2; e.addr = 32'h1234_5678; e.wdata = 32'hCAFE_F00D;
        bus_q.push_back(e);
        mem_en_i = 1'b1; mem_wen_i = 4'b1111; mem_addr_i = 32'h1234_5678; mem_wdata_i = 32'hCAFE_F00D;
        tick();
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        @(negedge clk);
        chk("t6_wait_addr", data_addr_o, 32'h1234_5678);
        #1;
        rst_n = 1'b0; mem_en_i = 1'b0;
        #1;
        chk("t6_rst_req",    {31'd0, data_req_o},     32'd0);
        chk("t6_rst_wr",     {31'd0, data_wr_o},      32'd0);
        chk("t6_rst_size",   {30'd0, data_size_o},    32'd0);
        chk("t6_rst_addr",   data_addr_o,  32'd0);
        chk("t6_rst_wdata",  data_wdata_o, 32'd0);
        chk("t6_rst_rdata",  mem_rdata_o,  32'd0);
        chk("t6_rst_rvalid", {31'd0, mem_rvalid_o},   32'd0);
        chk("t6_rst_stall",  {31'd0, mem_stallreq_o}, 32'd0);
        chk("t6_rst_cnt",    {28'd0, stall_cnt_o},    32'd0);
        tick();
        rst_n = 1'b1; data_data_ok_i = 1'b1;
        @(negedge clk);
        chk("t6_post_rst_rvalid", {31'd0, mem_rvalid_o}, 32'd0);
        tick();
        data_data_ok_i = 1'b0;
        mem_en_i = 1'b1; mem_wen_i = 4'b1111; mem_addr_i = 32'h8000_0200;
        for (int i = 1; i <= (1 << CNT_W) + 5; i++) begin
            tick();
            if (i == 5)  chk("cnt_5",  {28'd0, stall_cnt_o}, 32'd5);
            if (i == 15) chk("cnt_15", {28'd0, stall_cnt_o}, 32'd15);
        end
        chk("cnt_saturated", {28'd0, stall_cnt_o},     32'd15);
        chk("req_still_held", {31'd0, data_req_o},     32'd1);
        mem_en_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("rd_q_empty",  32'(rd_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
